ahb_slave_phase_ctrl: RTL and testbench

- AHB-Lite slave transfer sequencer in front of the endpoint register bank and data buffer.
- Accepts address phases and latches the control signals into data-phase registers.
- Drives register read/write strobes in the data phase.
- Inserts wait states while the data buffer is busy, and issues the two-cycle ERROR response for illegal accesses or wait timeouts.
- Keeps a saturating error counter for the status register.

---
 rtl/ahb_slave_phase_ctrl_if.sv | 27 ++
 rtl/ahb_slave_phase_ctrl.sv | 64 ++++++
 tb/tb_ahb_slave_phase_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ahb_slave_phase_ctrl_if.sv
// ahb_slave_phase_ctrl_if: AHB-Lite address/data-phase bundle between bus master and the phase sequencer.
interface ahb_slave_phase_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [1:0]        hsize;
    logic              hready;
    logic              buf_busy;
    logic              hreadyout;
    logic              hresp;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [1:0]        reg_size;
    logic [7:0]        err_cnt;
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hready, buf_busy,
        input  hreadyout, hresp, reg_wr_en, reg_rd_en, reg_addr, reg_size, err_cnt
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hready, buf_busy,
        output hreadyout, hresp, reg_wr_en, reg_rd_en, reg_addr, reg_size, err_cnt
    );
endinterface

// File: rtl/ahb_slave_phase_ctrl.sv
// ahb_slave_phase_ctrl: AHB-Lite slave sequencer latching address phases, driving register strobes,
// inserting busy wait states and issuing the two-cycle ERROR response.
module ahb_slave_phase_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 14,
    parameter int RO_REGS  = 2,
    parameter int MAX_WAIT = 8
) (
    input logic                   clk,
    input logic                   n_rst,
    ahb_slave_phase_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
    localparam int WW = $clog2(MAX_WAIT + 1);
    state_t            r_state;
    logic              r_dp_write;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [7:0]        r_err_cnt;
    logic [WW-1:0]     r_wait_cnt;
    logic              w_accept, w_err, w_hold, w_timeout, w_load;
    state_t            w_acc_state, w_next;
    assign w_accept = bus.hsel & bus.hready & bus.htrans[1];
    assign w_err = ({1'b0, bus.haddr} >= (ADDR_W+1)'(NUM_REGS))
                 | (bus.hwrite & ({1'b0, bus.haddr} < (ADDR_W+1)'(RO_REGS)))
                 | (bus.hsize == 2'd3)
                 | ((bus.hsize == 2'd1) & bus.haddr[0])
                 | ((bus.hsize == 2'd2) & (|bus.haddr[1:0]));
    assign w_hold      = (r_state == DATA) & bus.buf_busy;
    assign w_timeout   = w_hold & (r_wait_cnt == WW'(MAX_WAIT - 1));
    assign w_acc_state = !w_accept ? IDLE : (w_err ? ERR1 : DATA);
    // A new address phase is only taken when the current data phase is not stalled and not in ERR1.
    assign w_load      = w_accept & (r_state != ERR1) & !w_hold;
    assign w_next      = (r_state == ERR1) ? ERR2 : (w_hold ? (w_timeout ? ERR1 : DATA) : w_acc_state);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_dp_write <= 1'b0;
            r_addr     <= '0;
            r_size     <= '0;
            r_err_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_addr     <= bus.haddr;
                r_size     <= bus.hsize;
                r_dp_write <= bus.hwrite;
                r_wait_cnt <= '0;
            end else if (w_hold) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_next == ERR1 && r_err_cnt != 8'hff)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
    assign bus.hreadyout = (r_state == DATA) ? !bus.buf_busy : (r_state != ERR1);
    assign bus.hresp     = (r_state == ERR1) | (r_state == ERR2);
    assign bus.reg_wr_en = (r_state == DATA) & r_dp_write & !bus.buf_busy;
    assign bus.reg_rd_en = (r_state == DATA) & !r_dp_write & !bus.buf_busy;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_size  = r_size;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_ahb_slave_phase_ctrl.sv
// tb_ahb_slave_phase_ctrl: directed vectors with per-cycle expected outputs queued to a negedge monitor.
module tb_ahb_slave_phase_ctrl;
    localparam logic [1:0] ID = 2'd0, BZ = 2'd1, NS = 2'd2, SQ = 2'd3;
    typedef struct {
        logic [17:0] v;
        string       nm;
    } exp_t;
    logic clk, n_rst;
    exp_t q[$];
    int   checks, errors;
    ahb_slave_phase_ctrl_if #(.ADDR_W(4)) bus ();
    ahb_slave_phase_ctrl #(.ADDR_W(4), .NUM_REGS(14), .RO_REGS(2), .MAX_WAIT(8)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
    function automatic logic [17:0] ex(logic rdy, logic resp, logic wr, logic rd, logic [3:0] a, logic [1:0] s, logic [7:0] c);
        return {rdy, resp, wr, rd, a, s, c};
    endfunction
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = q.pop_front();
            act = {bus.hreadyout, bus.hresp, bus.reg_wr_en, bus.reg_rd_en, bus.reg_addr, bus.reg_size, bus.err_cnt};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got rdy=%b resp=%b wr=%b rd=%b addr=%0d size=%0d cnt=%0d, want rdy=%b resp=%b wr=%b rd=%b addr=%0d size=%0d cnt=%0d",
                    e.nm, act[17], act[16], act[15], act[14], act[13:10], act[9:8], act[7:0],
                    e.v[17], e.v[16], e.v[15], e.v[14], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
        end
    end
    task automatic cyc(input string nm, input logic sel, input logic [3:0] a, input logic [1:0] t, input logic w,
                       input logic [1:0] sz, input logic hr, input logic busy, input logic [17:0] e);
        exp_t x;
        bus.hsel = sel; bus.haddr = a; bus.htrans = t; bus.hwrite = w;
        bus.hsize = sz; bus.hready = hr; bus.buf_busy = busy;
        x.v = e; x.nm = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input string nm, input logic hr, input logic busy, input logic [17:0] e);
        cyc(nm, 0, 4'd0, ID, 0, 2'd0, hr, busy, e);
    endtask
    initial begin
        logic [7:0] c;
        checks = 0; errors = 0;
        n_rst = 0;
        bus.hsel = 0; bus.haddr = 0; bus.htrans = ID; bus.hwrite = 0;
        bus.hsize = 0; bus.hready = 1; bus.buf_busy = 0;
        @(posedge clk);
        #1;
        idle("reset", 1, 0, ex(1,0,0,0,0,0,0));
        n_rst = 1;
        idle("post_reset", 1, 0, ex(1,0,0,0,0,0,0));
        cyc("wr4_addr", 1, 4'd4, NS, 1, 2'd0, 1, 0, ex(1,0,0,0,0,0,0));
        idle("wr4_data", 1, 0, ex(1,0,1,0,4,0,0));
        idle("wr4_after", 1, 0, ex(1,0,0,0,4,0,0));
        cyc("rd2_addr", 1, 4'd2, NS, 0, 2'd1, 1, 0, ex(1,0,0,0,4,0,0));
        cyc("rd2_data_rd3_addr", 1, 4'd3, SQ, 0, 2'd0, 1, 0, ex(1,0,0,1,2,1,0));
        idle("rd3_data", 1, 0, ex(1,0,0,1,3,0,0));
        idle("b2b_after", 1, 0, ex(1,0,0,0,3,0,0));
        cyc("rd6_addr", 1, 4'd6, NS, 0, 2'd0, 1, 0, ex(1,0,0,0,3,0,0));
        for (int i = 0; i < 3; i++)
            idle("rd6_wait", 0, 1, ex(0,0,0,0,6,0,0));
        idle("rd6_done", 1, 0, ex(1,0,0,1,6,0,0));
        idle("rd6_after", 1, 0, ex(1,0,0,0,6,0,0));
        cyc("wr0_ro_addr", 1, 4'd0, NS, 1, 2'd0, 1, 0, ex(1,0,0,0,6,0,0));
        idle("wr0_err1", 0, 0, ex(0,1,0,0,0,0,1));
        idle("wr0_err2", 1, 0, ex(1,1,0,0,0,0,1));
        idle("wr0_after", 1, 0, ex(1,0,0,0,0,0,1));
        cyc("word5_addr", 1, 4'd5, NS, 0, 2'd2, 1, 0, ex(1,0,0,0,0,0,1));
        idle("word5_err1", 0, 0, ex(0,1,0,0,5,2,2));
        idle("word5_err2", 1, 0, ex(1,1,0,0,5,2,2));
        idle("word5_after", 1, 0, ex(1,0,0,0,5,2,2));
        cyc("addr14_addr", 1, 4'd14, NS, 0, 2'd0, 1, 0, ex(1,0,0,0,5,2,2));
        idle("addr14_err1", 0, 0, ex(0,1,0,0,14,0,3));
        cyc("addr14_err2_wr7_addr", 1, 4'd7, NS, 1, 2'd0, 1, 0, ex(1,1,0,0,14,0,3));
        idle("wr7_data", 1, 0, ex(1,0,1,0,7,0,3));
        cyc("hready_low_block", 1, 4'd8, NS, 1, 2'd0, 0, 0, ex(1,0,0,0,7,0,3));
        idle("hready_low_nostrobe", 1, 0, ex(1,0,0,0,7,0,3));
        cyc("busy_trans_addr", 1, 4'd8, BZ, 1, 2'd0, 1, 0, ex(1,0,0,0,7,0,3));
        idle("busy_trans_nostrobe", 1, 0, ex(1,0,0,0,7,0,3));
        cyc("half9_addr", 1, 4'd9, NS, 0, 2'd1, 1, 0, ex(1,0,0,0,7,0,3));
        idle("half9_err1", 0, 0, ex(0,1,0,0,9,1,4));
        idle("half9_err2", 1, 0, ex(1,1,0,0,9,1,4));
        idle("half9_after", 1, 0, ex(1,0,0,0,9,1,4));
        cyc("tmo_addr", 1, 4'd4, NS, 0, 2'd0, 1, 0, ex(1,0,0,0,9,1,4));
        for (int i = 0; i < 8; i++)
            idle("tmo_wait", 0, 1, ex(0,0,0,0,4,0,4));
        idle("tmo_err1", 0, 1, ex(0,1,0,0,4,0,5));
        idle("tmo_err2", 1, 1, ex(1,1,0,0,4,0,5));
        idle("tmo_after", 1, 1, ex(1,0,0,0,4,0,5));
        cyc("rst_addr", 1, 4'd10, NS, 1, 2'd0, 1, 0, ex(1,0,0,0,4,0,5));
        idle("rst_busy", 0, 1, ex(0,0,0,0,10,0,5));
        n_rst = 0;
        idle("rst_mid", 0, 1, ex(1,0,0,0,0,0,0));
        n_rst = 1;
        idle("rst_release", 1, 0, ex(1,0,0,0,0,0,0));
        cyc("rewr4_addr", 1, 4'd4, NS, 1, 2'd0, 1, 0, ex(1,0,0,0,0,0,0));
        idle("rewr4_data", 1, 0, ex(1,0,1,0,4,0,0));
        idle("rewr4_after", 1, 0, ex(1,0,0,0,4,0,0));
        cyc("sat_first_addr", 1, 4'd15, NS, 0, 2'd0, 1, 0, ex(1,0,0,0,4,0,0));
        for (int k = 1; k <= 256; k++) begin
            c = (k > 255) ? 8'd255 : 8'(k);
            idle("sat_err1", 0, 0, ex(0,1,0,0,15,0,c));
            if (k < 256)
                cyc("sat_err2_next", 1, 4'd15, NS, 0, 2'd0, 1, 0, ex(1,1,0,0,15,0,c));
            else
                idle("sat_err2_last", 1, 0, ex(1,1,0,0,15,0,c));
        end
        idle("sat_final", 1, 0, ex(1,0,0,0,15,0,255));
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
